bcd_serial_subtractor: RTL

//  Digit-serial multi-digit BCD subtractor; the inverse of the BCD addition path. Computes |a-b| over

---
 rtl/bcd_pkg.sv | 28 ++
 rtl/bcd_digit_sub.sv | 31 +++
 rtl/bcd_serial_subtractor.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared BCD definitions used by the calculator's BCD adder and subtractor.
//   BCD_W            bits per packed BCD digit
//   BCD_MAX          largest legal digit value
//   bcd_digit_t      one packed BCD digit
//   bcd_sub_state_t  control states of the serial subtractor
//   bcd_is_valid()   1 when a 4-bit digit is a legal BCD digit (0..9)
// -----------------------------------------------------------------------------
package bcd_pkg;

    localparam int BCD_W   = 4;
    localparam int BCD_MAX = 9;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } bcd_sub_state_t;

    function automatic logic bcd_is_valid(input bcd_digit_t v);
        return (v <= bcd_digit_t'(BCD_MAX));
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// -----------------------------------------------------------------------------
// bcd_digit_sub
// Combinational single-digit BCD subtract with borrow: d = x - y - bin, with a
// +10 correction and borrow-out whenever the raw difference goes negative.
//   x, y  [3:0]  BCD digits (both assumed <= 9)
//   bin          borrow in
//   d     [3:0]  corrected BCD result digit (always 0..9)
//   bout         borrow out
// -----------------------------------------------------------------------------
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  bcd_digit_t x,
    input  bcd_digit_t y,
    input  logic       bin,
    output bcd_digit_t d,
    output logic       bout
);

    // One extra bit holds the sign: for legal digits the raw result lies in
    // -10..9, which fits a 5-bit two's-complement value.
    logic [BCD_W:0] t;

    always_comb begin
        t    = {1'b0, x} - {1'b0, y} - {{BCD_W{1'b0}}, bin};
        bout = t[BCD_W];
        // Adding 10 modulo 16 maps -10..-1 onto 0..9.
        d    = bout ? (t[BCD_W-1:0] + bcd_digit_t'(10)) : t[BCD_W-1:0];
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// -----------------------------------------------------------------------------
// bcd_serial_subtractor
// Digit-serial |a-b| over DIGITS packed BCD digits, least significant digit
// first, one digit per clock. A final borrow means the result is in tens
// complement, so a second serial pass (0 - diff) turns it into a magnitude and
// neg is set.
//   clk     clock, rising edge
//   rst_n   asynchronous active-low reset
//   start   request, sampled only in IDLE
//   a, b    minuend / subtrahend, packed BCD, digit 0 in [3:0]
//   busy    high while subtracting or re-complementing
//   done    one-cycle pulse, result valid
//   diff    |a-b| packed BCD, held until the next accepted start
//   neg     a < b, valid with diff
//   err     some input digit was > 9, valid with diff
// -----------------------------------------------------------------------------
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BCD_W*DIGITS-1:0] a,
    input  logic [BCD_W*DIGITS-1:0] b,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] diff,
    output logic                    neg,
    output logic                    err
);

    localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);

    bcd_sub_state_t                   state_q;
    logic [IDX_W-1:0]                 idx_q;
    logic                             borrow_q;
    logic [DIGITS-1:0][BCD_W-1:0]     a_q;
    logic [DIGITS-1:0][BCD_W-1:0]     b_q;
    logic [DIGITS-1:0][BCD_W-1:0]     diff_q;
    logic                             neg_q;
    logic                             err_q;
    logic                             busy_q;
    logic                             done_q;

    // Input validity: one flag per digit position, checked on the live ports
    // so the decision is made in the same edge that latches the operands.
    logic [DIGITS-1:0] bad_digit;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_chk
            assign bad_digit[gi] = !bcd_is_valid(a[gi*BCD_W +: BCD_W]) ||
                                   !bcd_is_valid(b[gi*BCD_W +: BCD_W]);
        end
    endgenerate

    // The single digit subtractor is shared by both passes: a-b in SUB and
    // 0-diff in FIX.
    bcd_digit_t sub_x;
    bcd_digit_t sub_y;
    bcd_digit_t sub_d;
    logic       sub_bout;

    assign sub_x = (state_q == FIX) ? bcd_digit_t'(0) : a_q[idx_q];
    assign sub_y = (state_q == FIX) ? diff_q[idx_q]   : b_q[idx_q];

    bcd_digit_sub u_digit_sub (
        .x    (sub_x),
        .y    (sub_y),
        .bin  (borrow_q),
        .d    (sub_d),
        .bout (sub_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= 1'b0;
                        idx_q    <= '0;
                        neg_q    <= 1'b0;
                        diff_q   <= '0;
                        if (|bad_digit) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            err_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= SUB;
                        end
                    end
                end

                SUB: begin
                    diff_q[idx_q] <= sub_d;
                    if (idx_q == LAST_IDX) begin
                        idx_q <= '0;
                        if (sub_bout) begin
                            // Result is the tens complement of the magnitude.
                            borrow_q <= 1'b0;
                            neg_q    <= 1'b1;
                            state_q  <= FIX;
                        end else begin
                            borrow_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end
                    end else begin
                        borrow_q <= sub_bout;
                        idx_q    <= idx_q + 1'b1;
                    end
                end

                FIX: begin
                    diff_q[idx_q] <= sub_d;
                    if (idx_q == LAST_IDX) begin
                        // The final borrow of 0-x is always set here; drop it.
                        idx_q    <= '0;
                        borrow_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        borrow_q <= sub_bout;
                        idx_q    <= idx_q + 1'b1;
                    end
                end

                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign neg  = neg_q;
    assign err  = err_q;

endmodule
